rnn_cell_engine: RTL

//  Parametrised successor of the fixed 64x32 RNN core. Each step: h_t = act(W_ih*x_t + b_ih + W_hh*h_{t-1} + b_hh).

---
 rtl/rnn_cell_engine.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/rnn_cell_engine.sv
// RNN cell engine: h_t = act(W_ih*x_t + b_ih + W_hh*h_{t-1} + b_hh) over T timesteps.
// It fetches weights from a shared memory with 1-cycle read latency and writes each h_t[n] back to it.
module rnn_cell_engine #(
  parameter int H     = 64,
  parameter int XB    = 32,
  parameter int DW    = 20,
  parameter int FRAC  = 16,
  parameter int ACC_W = 48
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  input  logic          act_sel,
  input  logic [31:0]   idata,
  input  logic [DW-1:0] mdata_r,
  output logic          busy,
  output logic          done,
  output logic          i_en,
  output logic          mce,
  output logic [2:0]    msel,
  output logic [16:0]   maddr,
  output logic [DW-1:0] mdata_w
);

  localparam int NW = (H > 1) ? $clog2(H) : 1;
  localparam int KW = (XB > 1) ? $clog2(XB) : 1;

  localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1) << (FRAC - 1);
  localparam logic signed [ACC_W-1:0] ONE     = ACC_W'(1) << FRAC;
  localparam logic signed [ACC_W-1:0] NEG_ONE = -ONE;
  localparam logic signed [ACC_W-1:0] MAXP    = (ACC_W'(1) << (DW - 1)) - ACC_W'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_HDR_W, S_FETCH, S_LATCH, S_BIAS0, S_BIAS1,
    S_WIH, S_WHH, S_ACT, S_WB, S_COMMIT, S_DONE
  } state_t;

  typedef enum logic [1:0] {P_NONE, P_BIAS, P_WIH, P_WHH} pend_t;

  state_t                    state_reg, state_next;
  logic                      act_sel_reg;
  logic [10:0]               t_reg, t_max_reg;
  logic [NW-1:0]             n_reg, j_reg, pend_j_reg;
  logic [KW-1:0]             k_reg, pend_k_reg;
  logic [XB-1:0]             x_reg;
  pend_t                     pend_reg;
  logic signed [ACC_W-1:0]   acc_reg, acc_next;
  logic signed [DW-1:0]      h_old_reg [H];
  logic signed [DW-1:0]      h_tmp_reg [H];

  logic signed [ACC_W-1:0]   data_sh;
  logic signed [2*DW-1:0]    prod;
  logic signed [ACC_W-1:0]   rnd_sum, rnd, act_val;
  logic [DW-1:0]             act_result;
  logic                      unused_idata;

  assign unused_idata = ^idata;
  assign busy = (state_reg != S_IDLE);
  assign mce  = busy;

  // Memory data is one cycle behind its address, so accumulation follows the
  // schedule by one cycle through pend_reg; the ACT slot absorbs the last term.
  always_comb begin
    data_sh  = {{(ACC_W-DW){mdata_r[DW-1]}}, mdata_r} <<< FRAC;
    prod     = h_old_reg[pend_j_reg] * $signed(mdata_r);
    acc_next = acc_reg;
    case (pend_reg)
      P_BIAS: acc_next = acc_reg + data_sh;
      P_WIH:  if (x_reg[pend_k_reg]) acc_next = acc_reg + data_sh;
      P_WHH:  acc_next = acc_reg + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
      default: acc_next = acc_reg;
    endcase
  end

  always_comb begin
    rnd_sum = acc_reg + HALF;
    rnd     = rnd_sum >>> FRAC;
    act_val = rnd;
    if (!act_sel_reg) begin
      if (rnd > ONE)          act_val = ONE;
      else if (rnd < NEG_ONE) act_val = NEG_ONE;
    end else begin
      if (rnd < 0)            act_val = '0;
      else if (rnd > MAXP)    act_val = MAXP;
    end
    act_result = act_val[DW-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    i_en       = 1'b0;
    done       = 1'b0;
    msel       = 3'b100;
    maddr      = '0;
    mdata_w    = '0;
    case (state_reg)
      S_IDLE:  if (ready) state_next = S_HDR;
      S_HDR:   state_next = S_HDR_W;
      S_HDR_W: state_next = (mdata_r[10:0] == 11'd0) ? S_DONE : S_FETCH;
      S_FETCH: begin
        i_en       = 1'b1;
        state_next = S_LATCH;
      end
      S_LATCH: state_next = S_BIAS0;
      S_BIAS0: begin
        msel       = 3'b001;
        maddr      = 17'(n_reg);
        state_next = S_BIAS1;
      end
      S_BIAS1: begin
        msel       = 3'b011;
        maddr      = 17'(n_reg);
        state_next = S_WIH;
      end
      S_WIH: begin
        msel  = 3'b000;
        maddr = 17'({n_reg, k_reg});
        if (k_reg == KW'(XB - 1)) state_next = S_WHH;
      end
      S_WHH: begin
        msel  = 3'b010;
        maddr = 17'({n_reg, j_reg});
        if (j_reg == NW'(H - 1)) state_next = S_ACT;
      end
      S_ACT:   state_next = S_WB;
      S_WB: begin
        msel       = 3'b101;
        maddr      = 17'({t_reg, n_reg});
        mdata_w    = act_result;
        state_next = (n_reg == NW'(H - 1)) ? S_COMMIT : S_BIAS0;
      end
      S_COMMIT: state_next = ((t_reg + 11'd1) == t_max_reg) ? S_DONE : S_FETCH;
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_sel_reg <= 1'b0;
      t_reg       <= '0;
      t_max_reg   <= '0;
      n_reg       <= '0;
      k_reg       <= '0;
      j_reg       <= '0;
      x_reg       <= '0;
      pend_reg    <= P_NONE;
      pend_k_reg  <= '0;
      pend_j_reg  <= '0;
      acc_reg     <= '0;
    end else begin
      case (state_reg)
        S_IDLE:   if (ready) act_sel_reg <= act_sel;
        S_HDR_W: begin
          t_max_reg <= mdata_r[10:0];
          t_reg     <= '0;
        end
        S_LATCH: begin
          x_reg <= idata[XB-1:0];
          n_reg <= '0;
        end
        S_BIAS1:  k_reg <= '0;
        S_WIH: begin
          k_reg <= k_reg + 1'b1;
          j_reg <= '0;
        end
        S_WHH:    j_reg <= j_reg + 1'b1;
        S_WB:     n_reg <= n_reg + 1'b1;
        S_COMMIT: t_reg <= t_reg + 11'd1;
        default: ;
      endcase
      case (state_reg)
        S_BIAS0, S_BIAS1: pend_reg <= P_BIAS;
        S_WIH:            pend_reg <= P_WIH;
        S_WHH:            pend_reg <= P_WHH;
        default:          pend_reg <= P_NONE;
      endcase
      pend_k_reg <= k_reg;
      pend_j_reg <= j_reg;
      acc_reg    <= (state_reg == S_BIAS0) ? '0 : acc_next;
    end
  end

  // h_old only changes at COMMIT so every neuron of a step sees the same h_{t-1}.
  for (genvar gi = 0; gi < H; gi++) begin : g_hidden
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        h_old_reg[gi] <= '0;
        h_tmp_reg[gi] <= '0;
      end else begin
        if (state_reg == S_WB && n_reg == NW'(gi)) h_tmp_reg[gi] <= act_result;
        if (state_reg == S_COMMIT)                h_old_reg[gi] <= h_tmp_reg[gi];
      end
    end
  end

endmodule
